// File: rtl/quad_encoder_tx.sv
// Pushbutton-driven quadrature encoder emulator: two debounced buttons step a
// Gray-coded A/B phase pair and a wrapping position counter, rate-limited by a hold timer.
module quad_encoder_tx #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int PHASE_CYCLES    = 524288,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_up,
  input  logic             btn_down,
  output logic             quadA,
  output logic             quadB,
  output logic [CNT_W-1:0] position,
  output logic             busy
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TM_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TM_W-1:0] TM_LOAD = TM_W'(PHASE_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Phase index 0..3 maps to {A,B} = 00,10,11,01 so that forward steps lead with A.
  function automatic logic [1:0] gray_enc(input logic [1:0] idx);
    logic [1:0] ab;
    case (idx)
      2'd0:    ab = 2'b00;
      2'd1:    ab = 2'b10;
      2'd2:    ab = 2'b11;
      2'd3:    ab = 2'b01;
      default: ab = 2'b00;
    endcase
    return ab;
  endfunction

  // Bit 0 carries the up button, bit 1 the down button, throughout the front end.
  logic [1:0]            btn_raw;
  logic [1:0]            sync1_q, sync1_d;
  logic [1:0]            sync2_q, sync2_d;
  logic [1:0]            db_q, db_d;
  logic [1:0][DB_W-1:0]  cnt_q, cnt_d;

  state_t                state_q, state_d;
  logic [TM_W-1:0]       timer_q, timer_d;
  logic [1:0]            idx_q, idx_d;
  logic [1:0]            quad_q, quad_d;
  logic [CNT_W-1:0]      position_q, position_d;
  logic                  busy_q, busy_d;

  logic                  fwd_req;
  logic                  bwd_req;

  assign btn_raw = {btn_down, btn_up};

  // Synchronizer shift and per-button debounce counters.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    db_d    = db_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          db_d[i]  = sync2_q[i];
          cnt_d[i] = {DB_W{1'b0}};
        end else begin
          cnt_d[i] = cnt_q[i] + DB_W'(1'b1);
        end
      end else begin
        cnt_d[i] = {DB_W{1'b0}};
      end
    end
  end

  // Front-end state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
      db_q    <= 2'b00;
      cnt_q   <= {(2 * DB_W){1'b0}};
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  // A press of both buttons cancels out rather than favouring one direction.
  assign fwd_req = db_q[0] & ~db_q[1];
  assign bwd_req = db_q[1] & ~db_q[0];

  // Step sequencer: emit on request from IDLE, then hold for PHASE_CYCLES clocks.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    idx_d      = idx_q;
    position_d = position_q;
    busy_d     = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (fwd_req || bwd_req) begin
          state_d = ST_HOLD;
          timer_d = TM_LOAD;
          busy_d  = 1'b1;
          if (fwd_req) begin
            idx_d      = idx_q + 2'd1;
            position_d = position_q + CNT_W'(1'b1);
          end else begin
            idx_d      = idx_q - 2'd1;
            position_d = position_q - CNT_W'(1'b1);
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_HOLD: begin
        if (timer_q == {TM_W{1'b0}}) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          timer_d = timer_q - TM_W'(1'b1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = {TM_W{1'b0}};
        busy_d  = 1'b0;
      end
    endcase
    quad_d = gray_enc(idx_d);
  end

  // Sequencer and output registers; reset is the only non-Gray output change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= {TM_W{1'b0}};
      idx_q      <= 2'd0;
      quad_q     <= 2'b00;
      position_q <= {CNT_W{1'b0}};
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      quad_q     <= quad_d;
      position_q <= position_d;
      busy_q     <= busy_d;
    end
  end

  assign quadA    = quad_q[1];
  assign quadB    = quad_q[0];
  assign position = position_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_quad_encoder_tx.sv
// Scoreboard bench for quad_encoder_tx: each button hold predicts its step edges,
// a negedge monitor pops a prediction whenever the quad outputs or position change.
module tb_quad_encoder_tx;

  localparam int D = 4;
  localparam int P = 8;
  localparam int W = 4;

  typedef struct {
    int         cyc;
    logic [1:0] ab;
    logic [3:0] pos;
    bit         ng;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         btn_up;
  logic         btn_down;
  logic         quadA;
  logic         quadB;
  logic [W-1:0] position;
  logic         busy;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   next_free = 0;
  int   busy_fall_cyc = -1;
  bit   mon_en = 1'b0;
  ev_t  exp_q[$];
  logic [1:0] exp_idx = 2'd0;
  logic [3:0] exp_pos = 4'd0;
  logic [1:0] prev_ab = 2'b00;
  logic [3:0] prev_pos = 4'd0;
  logic [1:0] gray_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  quad_encoder_tx #(
    .DEBOUNCE_CYCLES(D),
    .PHASE_CYCLES(P),
    .CNT_W(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .quadA(quadA),
    .quadB(quadB),
    .position(position),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Predict the step edges of a press sampled first at edge k and released (sampled) at k+len.
  task automatic plan(input int dir, input int k, input int len);
    ev_t ev;
    int  e;
    e = k + D + 2;
    if (e < next_free) e = next_free;
    while (e <= k + len + D + 1) begin
      if (dir == 0) begin
        exp_idx = exp_idx + 2'd1;
        exp_pos = exp_pos + 4'd1;
      end else begin
        exp_idx = exp_idx - 2'd1;
        exp_pos = exp_pos - 4'd1;
      end
      ev.cyc = e;
      ev.ab  = gray_tab[exp_idx];
      ev.pos = exp_pos;
      ev.ng  = 1'b0;
      exp_q.push_back(ev);
      next_free = e + P + 1;
      e = next_free;
    end
  endtask

  task automatic set_btn(input int dir, input logic v);
    if (dir == 0) btn_up = v;
    else btn_down = v;
  endtask

  // Called on a negedge; returns on the negedge where the release is driven.
  task automatic hold(input int dir, input int len);
    set_btn(dir, 1'b1);
    plan(dir, cyc + 1, len);
    repeat (len) @(negedge clk);
    set_btn(dir, 1'b0);
  endtask

  task automatic assert_reset();
    ev_t ev;
    rst = 1'b1;
    if (exp_pos != 4'd0 || exp_idx != 2'd0) begin
      ev.cyc = cyc + 1;
      ev.ab  = 2'b00;
      ev.pos = 4'd0;
      ev.ng  = 1'b1;
      exp_q.push_back(ev);
    end
    exp_idx = 2'd0;
    exp_pos = 4'd0;
    next_free = 0;
    busy_fall_cyc = -1;
  endtask

  task automatic settle();
    repeat (2 * P + D + 6) @(negedge clk);
    check_eq("drain", exp_q.size(), 0);
    check_eq("idle_busy", int'(busy), 0);
  endtask

  // Monitor: every observed output change must match the oldest prediction.
  always @(negedge clk) begin
    ev_t ev;
    if (mon_en) begin
      if ({quadA, quadB} !== prev_ab || position !== prev_pos) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_step", cyc, -1);
        end else begin
          ev = exp_q.pop_front();
          check_eq("step_cycle", cyc, ev.cyc);
          check_eq("step_ab", int'({quadA, quadB}), int'(ev.ab));
          check_eq("step_pos", int'(position), int'(ev.pos));
          if (!ev.ng) begin
            check_eq("one_bit", $countones({quadA, quadB} ^ prev_ab), 1);
            check_eq("busy_rise", int'(busy), 1);
            busy_fall_cyc = ev.cyc + P;
          end
        end
      end
      if (busy_fall_cyc > 0 && cyc == busy_fall_cyc - 1) check_eq("busy_hold", int'(busy), 1);
      if (busy_fall_cyc > 0 && cyc == busy_fall_cyc) check_eq("busy_fall", int'(busy), 0);
    end
    prev_ab  = {quadA, quadB};
    prev_pos = position;
  end

  initial begin
    rst      = 1'b1;
    btn_up   = 1'b1;
    btn_down = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("reset_out", int'({quadA, quadB, busy, position}), 0);
    end
    rst      = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    @(negedge clk);
    check_eq("post_reset_out", int'({quadA, quadB, busy, position}), 0);
    mon_en = 1'b1;

    // Forward hold: seven steps, the first four at k+6, k+15, k+24, k+33.
    hold(0, 60);
    settle();

    // Bounce shorter than the debounce window is ignored.
    for (int i = 0; i < 30; i++) begin
      btn_up = ((i / 2) % 2) == 0;
      @(negedge clk);
      check_eq("bounce_busy", int'(busy), 0);
    end
    btn_up = 1'b0;
    settle();
    check_eq("bounce_pos", int'(position), 7);

    // Both pressed cancel out.
    btn_up   = 1'b1;
    btn_down = 1'b1;
    repeat (40) @(negedge clk);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    settle();

    // Reversal: one step up, then straight into one step down.
    assert_reset();
    @(negedge clk);
    rst = 1'b0;
    hold(0, 5);
    hold(1, 5);
    settle();
    check_eq("reversal_pos", int'(position), 0);

    // Wrap-around: 16 forward steps, then one backward.
    hold(0, 140);
    settle();
    check_eq("wrap_pos", int'(position), 0);
    hold(1, 5);
    settle();
    check_eq("wrap_back_pos", int'(position), 15);
    check_eq("wrap_back_ab", int'({quadA, quadB}), 1);

    // Reset in the middle of a hold, button kept pressed across it.
    assert_reset();
    @(negedge clk);
    rst = 1'b0;
    settle();
    btn_up = 1'b1;
    plan(0, cyc + 1, 11);
    repeat (17) @(negedge clk);
    check_eq("mid_ab", int'({quadA, quadB}), 3);
    check_eq("mid_busy", int'(busy), 1);
    assert_reset();
    @(negedge clk);
    check_eq("mid_rst_busy", int'(busy), 0);
    rst = 1'b0;
    plan(0, cyc + 1, 5);
    repeat (5) @(negedge clk);
    btn_up = 1'b0;
    settle();
    check_eq("mid_final_pos", int'(position), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/quad_encoder_tx.md
# quad_encoder_tx

Quadrature encoder emulator: converts two raw pushbuttons (up/down) into a standard two-phase Gray-code quadrature pair (quadA/quadB) plus a running step position. It is the transmitting end of the paddle quadrature interface. It lets a player or a second board drive the paddle without a rotary encoder, and lets benches generate legal encoder traffic. It sits on the 100 MHz board clock domain and its quadA/quadB outputs connect directly to the paddle quadrature inputs.

## Interface
- DEBOUNCE_CYCLES, default 1000000: consecutive stable clocks (after synchronizer) required to accept a button level change (10 ms at 100 MHz).
- PHASE_CYCLES, default 524288: minimum clocks between consecutive quadrature transitions; also the auto-repeat period while a button is held.
- CNT_W, default 16: width of the position counter.
- clk  input  1  100 MHz board clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- btn_up  input  1  raw asynchronous pushbutton, high = pressed; steps forward.
- btn_down  input  1  raw asynchronous pushbutton, high = pressed; steps backward.
- quadA  output  1  quadrature phase A, registered.
- quadB  output  1  quadrature phase B, registered.
- position  output  CNT_W  two's-complement count of steps emitted (+1 forward, -1 backward), registered.
- busy  output  1  high while the phase hold timer is running (no new step may be emitted).

## Operation
- Synchronizer: each button passes through a 2-flop synchronizer, reset to 0.
- Debouncer, per button: the debounced level flips only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive clocks. Any clock where they are equal clears the counter. Counter width is clog2(DEBOUNCE_CYCLES+1).
- Phase state: 2-bit Gray index; forward sequence of {quadA,quadB} is 00 → 10 → 11 → 01 → 00 (A leads B); backward is the exact reverse. Exactly one output bit changes per step, always.
- Step request: fwd = up_db & ~down_db; bwd = down_db & ~up_db. Both or neither pressed means no request.
- FSM states:
  - IDLE (timer = 0, busy = 0): a request emits a step on the next edge, loads the timer with PHASE_CYCLES-1 and enters HOLD.
  - HOLD (busy = 1): the timer decrements each clock; at 0 it returns to IDLE.
  - A request still present on entry to IDLE emits the next step on the following edge. While a button is held, transitions are therefore spaced exactly PHASE_CYCLES+1 clocks apart.
- Direction reversal: allowed on any step; the phase index moves back one position. No illegal two-bit jump.
- position: +1 on a forward step, -1 on a backward step, on the same edge the quad outputs change. It wraps modulo 2^CNT_W, so max+1 → 0 and 0-1 → all-ones.
- Release during HOLD: the current hold completes and no further step is emitted. A step already emitted is never retracted.

## Timing
- Reset values: quadA=0, quadB=0, position=0, busy=0, phase index 0, timer 0, synchronizers and debounced levels 0, debounce counters 0.
- Reset mid-operation: all state returns to reset values on the reset edge. If the outputs were not 00, this forces one (possibly two-bit) line change; this is the only permitted non-Gray transition.
- Press latency: if a raw press is first sampled at edge k and held stable, the debounced level rises at edge k+DEBOUNCE_CYCLES+1 and the first quad transition appears at edge k+DEBOUNCE_CYCLES+2. Release latency is identical.
- busy rises on the step edge and falls PHASE_CYCLES clocks later.
- All outputs are direct flop outputs with no combinational path from inputs.

## Test plan
Use DEBOUNCE_CYCLES=4, PHASE_CYCLES=8, CNT_W=4 unless stated.
- Reset: assert rst 3 clocks with buttons pressed → quadA=0, quadB=0, position=0, busy=0 throughout and 1 clock after release of rst (buttons low).
- Forward hold: btn_up high from edge k for 60 clocks → {A,B} goes 10 at k+6, 11 at k+15, 01 at k+24, 00 at k+33; position 1,2,3,4 on those edges; every transition changes exactly one bit.
- Bounce rejection: btn_up toggled every 2 clocks for 30 clocks, then low → no quad change, position stays 0, busy stays 0.
- Both pressed / reversal: both buttons held 40 clocks → no change. Then up only → AB=10, position=1. Then down only → AB=00, position=0, spacing ≥ 9 clocks.
- Wrap-around: 16 forward steps from reset → position returns to 0 with AB=00. One backward step → position=15, AB=01.
- Reset mid-hold: reach AB=11, busy=1, assert rst one clock → next edge AB=00, position=0, busy=0. No step for DEBOUNCE_CYCLES+1 clocks after rst deasserts even if btn_up is held.
